// File: rtl/decoder_pkg.sv
// Shared types and code points for the pulsed 2-to-4 decoder.
// Pure declarations: no logic, no latency, no backpressure.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [1:0] CODE_Y0 = 2'd0;
  localparam logic [1:0] CODE_Y1 = 2'd1;
  localparam logic [1:0] CODE_Y2 = 2'd2;
  localparam logic [1:0] CODE_Y3 = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/decoder_pulse_2to4_sat_counter.sv
// Saturating hit counter: increments by one per inc, sticks at all-ones, clr wins.
// One-cycle update latency; no backpressure.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {CNT_W{1'b1}})) begin
      r_q <= r_q + CNT_W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/decoder_pulse_2to4.sv
// Pulsed 2-to-4 decoder: an accepted code drives its y line for PULSE_LEN cycles, then GAP_LEN idle.
// y rises one cycle after accept; ready is low from accept until the pulse and gap have elapsed.
module decoder_pulse_2to4
  import decoder_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  output logic             ready,
  input  logic             e,
  input  logic             a1,
  input  logic             a0,
  output logic             y3,
  output logic             y2,
  output logic             y1,
  output logic             y0,
  output logic             dis,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt3,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt0
);

  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] GAP_LOAD   = (GAP_LEN > 0) ? TW'(GAP_LEN - 1) : '0;

  state_t          r_state;
  logic [TW-1:0]   r_tmr;
  logic [3:0]      r_y;
  logic            r_dis;

  logic            w_accept;
  logic [1:0]      w_code;
  logic [3:0]      w_hit;
  logic [CNT_W-1:0] w_cnt [4];

  assign ready    = (r_state == ST_IDLE);
  assign w_accept = valid && ready;
  assign w_code   = {a1, a0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_y     <= '0;
      r_dis   <= 1'b0;
    end else begin
      r_dis <= w_accept && !e;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && e) begin
            r_y     <= onehot4(w_code);
            r_tmr   <= PULSE_LOAD;
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_tmr == '0) begin
            r_y <= '0;
            if (GAP_LEN > 0) begin
              r_tmr   <= GAP_LOAD;
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_tmr <= r_tmr - TW'(1);
          end
        end
        ST_GAP: begin
          if (r_tmr == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_tmr <= r_tmr - TW'(1);
          end
        end
        default: begin
          r_y     <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Disabled requests never count as a hit.
  assign w_hit[0] = w_accept && e && (w_code == CODE_Y0);
  assign w_hit[1] = w_accept && e && (w_code == CODE_Y1);
  assign w_hit[2] = w_accept && e && (w_code == CODE_Y2);
  assign w_hit[3] = w_accept && e && (w_code == CODE_Y3);

  for (genvar g = 0; g < 4; g++) begin : g_hit
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (w_hit[g]),
      .q     (w_cnt[g])
    );
  end

  assign {y3, y2, y1, y0} = r_y;
  assign dis  = r_dis;
  assign cnt0 = w_cnt[0];
  assign cnt1 = w_cnt[1];
  assign cnt2 = w_cnt[2];
  assign cnt3 = w_cnt[3];

endmodule

// File: tb/tb_decoder_pulse_2to4.sv
// Directed bench for decoder_pulse_2to4: default build, CNT_W=2 build and GAP_LEN=0 build.
module tb_decoder_pulse_2to4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   = 1'b0;
  logic       e       = 1'b0;
  logic       a1      = 1'b0;
  logic       a0      = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [2:0] valid_v = 3'b000;
  wire  [2:0] ready_v;
  wire  [2:0] dis_v;
  wire  [3:0] y_m, y_s, y_g;
  wire  [3:0][7:0] cnt_m;
  wire  [3:0][1:0] cnt_s;
  wire  [3:0][7:0] cnt_g;

  int n_pass   = 0;
  int n_total  = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  decoder_pulse_2to4 #(.PULSE_LEN(4), .GAP_LEN(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid_v[0]), .ready(ready_v[0]),
    .e(e), .a1(a1), .a0(a0),
    .y3(y_m[3]), .y2(y_m[2]), .y1(y_m[1]), .y0(y_m[0]),
    .dis(dis_v[0]), .clr_cnt(clr_cnt),
    .cnt3(cnt_m[3]), .cnt2(cnt_m[2]), .cnt1(cnt_m[1]), .cnt0(cnt_m[0])
  );

  decoder_pulse_2to4 #(.PULSE_LEN(4), .GAP_LEN(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .valid(valid_v[1]), .ready(ready_v[1]),
    .e(e), .a1(a1), .a0(a0),
    .y3(y_s[3]), .y2(y_s[2]), .y1(y_s[1]), .y0(y_s[0]),
    .dis(dis_v[1]), .clr_cnt(clr_cnt),
    .cnt3(cnt_s[3]), .cnt2(cnt_s[2]), .cnt1(cnt_s[1]), .cnt0(cnt_s[0])
  );

  decoder_pulse_2to4 #(.PULSE_LEN(4), .GAP_LEN(0), .CNT_W(8)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .valid(valid_v[2]), .ready(ready_v[2]),
    .e(e), .a1(a1), .a0(a0),
    .y3(y_g[3]), .y2(y_g[2]), .y1(y_g[1]), .y0(y_g[0]),
    .dis(dis_v[2]), .clr_cnt(clr_cnt),
    .cnt3(cnt_g[3]), .cnt2(cnt_g[2]), .cnt1(cnt_g[1]), .cnt0(cnt_g[0])
  );

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents a request (from a negedge), waits for ready, and returns at the negedge after edge T.
  task automatic do_accept(input int which, input logic [1:0] c, input logic en,
                           input logic clr, output int t_acc);
    int k;
    k = 0;
    e = en; a1 = c[1]; a0 = c[0];
    valid_v[which] = 1'b1;
    while (!ready_v[which] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) begin
      n_total++;
      $display("FAIL accept_timeout dut=%0d ready stayed 0, required 1", which);
    end
    clr_cnt = clr;
    @(negedge clk);
    t_acc   = edge_cnt;
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    n_total++; if (y_m !== 4'b0000) $display("FAIL reset_y_during got %b want 0000", y_m); else n_pass++;
    n_total++; if (ready_v[0] !== 1'b1) $display("FAIL reset_ready_during got %b want 1", ready_v[0]); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (y_m !== 4'b0000) $display("FAIL reset_y got %b want 0000", y_m); else n_pass++;
    n_total++; if (ready_v[0] !== 1'b1) $display("FAIL reset_ready got %b want 1", ready_v[0]); else n_pass++;
    n_total++; if (dis_v[0] !== 1'b0) $display("FAIL reset_dis got %b want 0", dis_v[0]); else n_pass++;
    n_total++; if (cnt_m !== 32'h0) $display("FAIL reset_cnt got %h want 00000000", cnt_m); else n_pass++;
  endtask

  task automatic test_single;
    int t;
    do_accept(0, 2'b10, 1'b1, 1'b0, t);
    valid_v[0] = 1'b0;
    n_total++; if (y_m !== 4'b0100) $display("FAIL single_y_t1 got %b want 0100", y_m); else n_pass++;
    n_total++; if (ready_v[0] !== 1'b0) $display("FAIL single_ready_t1 got %b want 0", ready_v[0]); else n_pass++;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      n_total++;
      if (y_m !== 4'b0100 || ready_v[0] !== 1'b0)
        $display("FAIL single_pulse_t%0d got y=%b ready=%b want y=0100 ready=0", i, y_m, ready_v[0]);
      else n_pass++;
    end
    @(negedge clk);
    n_total++; if (y_m !== 4'b0000) $display("FAIL single_y_t5 got %b want 0000", y_m); else n_pass++;
    n_total++; if (ready_v[0] !== 1'b0) $display("FAIL single_ready_gap got %b want 0", ready_v[0]); else n_pass++;
    @(negedge clk);
    n_total++; if (ready_v[0] !== 1'b1) $display("FAIL single_ready_back got %b want 1", ready_v[0]); else n_pass++;
    n_total++; if (cnt_m !== 32'h00010000) $display("FAIL single_cnt got %h want 00010000", cnt_m); else n_pass++;
  endtask

  task automatic test_disabled;
    int t;
    do_accept(0, 2'b01, 1'b0, 1'b0, t);
    valid_v[0] = 1'b0;
    n_total++; if (dis_v[0] !== 1'b1) $display("FAIL dis_pulse got %b want 1", dis_v[0]); else n_pass++;
    n_total++; if (y_m !== 4'b0000) $display("FAIL dis_y got %b want 0000", y_m); else n_pass++;
    n_total++; if (ready_v[0] !== 1'b1) $display("FAIL dis_ready got %b want 1", ready_v[0]); else n_pass++;
    @(negedge clk);
    n_total++; if (dis_v[0] !== 1'b0) $display("FAIL dis_one_cycle got %b want 0", dis_v[0]); else n_pass++;
    n_total++; if (cnt_m !== 32'h00010000) $display("FAIL dis_cnt got %h want 00010000", cnt_m); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int t[5];
    logic [3:0] oh;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_accept(0, 2'(i), 1'b1, 1'b0, t[i]);
      oh = 4'b0001 << i;
      n_total++; if (y_m !== oh) $display("FAIL b2b_y%0d_first got %b want %b", i, y_m, oh); else n_pass++;
      for (int j = 1; j < 4; j++) begin
        @(negedge clk);
        n_total++; if (y_m !== oh) $display("FAIL b2b_y%0d_hold got %b want %b", i, y_m, oh); else n_pass++;
      end
      @(negedge clk);
      n_total++;
      if (y_m !== 4'b0000 || ready_v[0] !== 1'b0)
        $display("FAIL b2b_gap%0d got y=%b ready=%b want y=0000 ready=0", i, y_m, ready_v[0]);
      else n_pass++;
    end
    do_accept(0, 2'b11, 1'b1, 1'b0, t[4]);
    valid_v[0] = 1'b0;
    for (int i = 1; i < 5; i++) begin
      n_total++;
      if (t[i] - t[i-1] != 6) $display("FAIL b2b_spacing%0d got %0d want 6", i, t[i] - t[i-1]);
      else n_pass++;
    end
    n_total++; if (y_m !== 4'b1000) $display("FAIL b2b_second3 got %b want 1000", y_m); else n_pass++;
    repeat (5) @(negedge clk);
    n_total++; if (ready_v[0] !== 1'b1) $display("FAIL b2b_ready_end got %b want 1", ready_v[0]); else n_pass++;
    n_total++; if (cnt_m !== 32'h02010101) $display("FAIL b2b_cnt got %h want 02010101", cnt_m); else n_pass++;
  endtask

  task automatic test_saturation;
    int t;
    logic [1:0] exp3 [5];
    exp3 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_accept(1, 2'b11, 1'b1, 1'b0, t);
      n_total++;
      if (cnt_s[3] !== exp3[i]) $display("FAIL sat_cnt3_hit%0d got %0d want %0d", i + 1, cnt_s[3], exp3[i]);
      else n_pass++;
    end
    do_accept(1, 2'b11, 1'b1, 1'b1, t);
    valid_v[1] = 1'b0;
    n_total++; if (cnt_s[3] !== 2'd0) $display("FAIL sat_clear_wins got %0d want 0", cnt_s[3]); else n_pass++;
    n_total++; if (y_s !== 4'b1000) $display("FAIL sat_clr_no_fsm_effect got %b want 1000", y_s); else n_pass++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int t;
    do_reset();
    do_accept(0, 2'b01, 1'b1, 1'b0, t);
    valid_v[0] = 1'b0;
    n_total++; if (y_m !== 4'b0010) $display("FAIL midrst_y_before got %b want 0010", y_m); else n_pass++;
    n_total++; if (cnt_m[1] !== 8'd1) $display("FAIL midrst_cnt1_before got %0d want 1", cnt_m[1]); else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (y_m !== 4'b0000) $display("FAIL midrst_y_async got %b want 0000", y_m); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (ready_v[0] !== 1'b1) $display("FAIL midrst_ready got %b want 1", ready_v[0]); else n_pass++;
    n_total++; if (y_m !== 4'b0000) $display("FAIL midrst_no_resume got %b want 0000", y_m); else n_pass++;
    n_total++; if (cnt_m[1] !== 8'd0) $display("FAIL midrst_cnt1 got %0d want 0", cnt_m[1]); else n_pass++;
  endtask

  task automatic test_gap0;
    int t;
    do_reset();
    do_accept(2, 2'b10, 1'b1, 1'b0, t);
    valid_v[2] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      n_total++;
      if (y_g !== 4'b0100 || ready_v[2] !== 1'b0)
        $display("FAIL gap0_pulse_t%0d got y=%b ready=%b want y=0100 ready=0", i, y_g, ready_v[2]);
      else n_pass++;
    end
    @(negedge clk);
    n_total++; if (y_g !== 4'b0000) $display("FAIL gap0_y_end got %b want 0000", y_g); else n_pass++;
    n_total++; if (ready_v[2] !== 1'b1) $display("FAIL gap0_ready_t4 got %b want 1", ready_v[2]); else n_pass++;
    n_total++; if (cnt_g[2] !== 8'd1) $display("FAIL gap0_cnt2 got %0d want 1", cnt_g[2]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_disabled();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    test_gap0();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
